// File: rtl/isa_pkg.sv
// ISA constants shared by the program-load path: classes, sub-opcodes, error codes, loader state.
// No logic, no latency, no backpressure.
package isa_pkg;

    localparam logic [1:0] CLS_MATH = 2'b00;
    localparam logic [1:0] CLS_BR   = 2'b01;
    localparam logic [1:0] CLS_ASG  = 2'b10;
    localparam logic [1:0] CLS_VAL  = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam logic [2:0] OP_BL  = 3'b000;
    localparam logic [2:0] OP_BG  = 3'b001;
    localparam logic [2:0] OP_BNE = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;

    // Assign/mem ops 001, 110 and 111 are reserved encodings.
    localparam logic [2:0] OP_LI    = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_CMP   = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_JMP = 3'b001;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RSVD  = 2'b01;
    localparam logic [1:0] ERR_FIELD = 2'b10;
    localparam logic [1:0] ERR_MEM   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/instr_packer.sv
// Packs decoded fields into the 9-bit machine word and flags reserved/overflowing encodings.
// Purely combinational, no backpressure.
module instr_packer
    import isa_pkg::*;
(
    input  logic [1:0] in_type,
    input  logic [2:0] in_op,
    input  logic [5:0] in_operand,
    output logic [8:0] word,
    output logic       legal,
    output logic [1:0] code
);

    always_comb begin
        word = {in_type, 7'b0};
        code = ERR_NONE;
        case (in_type)
            CLS_MATH: begin
                word[6:4] = in_op;
                word[3:0] = in_operand[3:0];
                if (in_operand[5:4] != 2'b00) code = ERR_FIELD;
            end
            CLS_BR: begin
                word[6:5] = in_op[1:0];
                word[4:0] = in_operand[4:0];
                if (in_op[2] || in_operand[5]) code = ERR_FIELD;
            end
            CLS_ASG: begin
                word[6:4] = in_op;
                word[3:0] = in_operand[3:0];
                // A reserved op outranks any field overflow.
                if (in_op == 3'b001 || in_op == 3'b110 || in_op == 3'b111)
                    code = ERR_RSVD;
                else if (in_operand[5:4] != 2'b00)
                    code = ERR_FIELD;
            end
            default: begin
                word[6]   = in_op[0];
                word[5:0] = in_operand;
                if (in_op[2:1] != 2'b00) code = ERR_FIELD;
            end
        endcase
        legal = (code == ERR_NONE);
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles and writes them sequentially into instruction memory from base_addr.
// Latency 1 cycle, 1 word/cycle; in_ready is high only while a session is accepting.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [2:0]        in_op,
    input  logic [5:0]        in_operand,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [8:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        word;
    logic              legal;
    logic [1:0]        code;

    instr_packer u_packer (
        .in_type    (in_type),
        .in_op      (in_op),
        .in_operand (in_operand),
        .word       (word),
        .legal      (legal),
        .code       (code)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        if (!legal) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= code;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= word;
                            count     <= count + 1'b1;
                            if (in_last) begin
                                state    <= ST_DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else if (ptr >= LAST_ADDR) begin
                                // Word at the top address lands; the session cannot continue.
                                state    <= ST_ERR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                err_code <= ERR_MEM;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state    <= ST_ACCEPT;
                        ptr      <= base_addr;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        count    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: vector table, directed corner cases, random sessions.
module tb_instr_encoder_loader;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       start;
    logic [7:0] base_addr;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_type;
    logic [2:0] in_op;
    logic [5:0] in_operand;
    logic       in_last;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [8:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [8:0] count;

    instr_encoder_loader #(.ADDR_W(8), .MEM_DEPTH(256)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_op      (in_op),
        .in_operand (in_operand),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .count      (count)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && mem_we === 1'b1) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_wdata));
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding straight from the class rules, using plain arithmetic.
    task automatic ref_pack(input int t, input int op, input int opd, output int w, output int c);
        c = 0;
        case (t)
            0: begin
                if (opd >= 16) c = 2;
                w = op * 16 + opd % 16;
            end
            1: begin
                if (op >= 4 || opd >= 32) c = 2;
                w = 128 + (op % 4) * 32 + opd % 32;
            end
            2: begin
                if (op == 1 || op == 6 || op == 7) c = 1;
                else if (opd >= 16) c = 2;
                w = 256 + op * 16 + opd % 16;
            end
            default: begin
                if (op >= 2) c = 2;
                w = 384 + (op % 2) * 64 + opd;
            end
        endcase
    endtask

    int bt[8], bo[8], bd[8], bl[8];
    int ex_addr[$];
    int ex_data[$];

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Starts a session and streams bundles with in_valid held high until in_ready drops.
    task automatic exec(input logic [7:0] base, input int n, output int acc);
        clear_log();
        @(negedge Clk);
        start = 1'b1;
        base_addr = base;
        @(negedge Clk);
        start = 1'b0;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (in_ready !== 1'b1) break;
            in_valid   = 1'b1;
            in_type    = 2'(bt[i]);
            in_op      = 3'(bo[i]);
            in_operand = 6'(bd[i]);
            in_last    = bl[i][0];
            acc++;
            @(negedge Clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge Clk);
    endtask

    task automatic model(input int base, input int n, output int e_acc, output int e_done,
                         output int e_err, output int e_code, output int e_cnt);
        int p, w, c;
        p = base;
        e_acc = 0; e_done = 0; e_err = 0; e_code = 0; e_cnt = 0;
        ex_addr.delete();
        ex_data.delete();
        for (int i = 0; i < n; i++) begin
            e_acc++;
            ref_pack(bt[i], bo[i], bd[i], w, c);
            if (c != 0) begin
                e_err = 1; e_code = c;
                break;
            end
            ex_addr.push_back(p);
            ex_data.push_back(w);
            e_cnt++;
            if (bl[i] != 0) begin
                e_done = 1;
                break;
            end
            if (p == 255) begin
                e_err = 1; e_code = 3;
                break;
            end
            p++;
        end
    endtask

    task automatic run_and_compare(input string tag, input int base, input int n);
        int acc, e_acc, e_done, e_err, e_code, e_cnt;
        model(base, n, e_acc, e_done, e_err, e_code, e_cnt);
        exec(8'(base), n, acc);
        check({tag, " accepted"}, 32'(acc), 32'(e_acc));
        check({tag, " nwrites"}, 32'(wr_addr.size()), 32'(ex_addr.size()));
        for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
            check({tag, " addr"}, 32'(wr_addr[i]), 32'(ex_addr[i]));
            check({tag, " wdata"}, 32'(wr_data[i]), 32'(ex_data[i]));
        end
        check({tag, " done"}, 32'(done), 32'(e_done));
        check({tag, " err"}, 32'(err), 32'(e_err));
        check({tag, " err_code"}, 32'(err_code), 32'(e_code));
        check({tag, " count"}, 32'(count), 32'(e_cnt));
        check({tag, " busy"}, 32'(busy), 32'((e_done == 0 && e_err == 0) ? 1 : 0));
        check({tag, " in_ready"}, 32'(in_ready), 32'((e_done == 0 && e_err == 0) ? 1 : 0));
    endtask

    typedef struct {
        int t;
        int op;
        int opd;
        int word;
        int code;
    } vec_t;

    task automatic gen_bundle(input int i, input int last);
        bt[i] = $urandom_range(0, 3);
        bo[i] = $urandom_range(0, 7);
        bd[i] = $urandom_range(0, 63);
        bl[i] = last;
        if ($urandom_range(0, 3) != 0) begin
            case (bt[i])
                0: bd[i] = bd[i] % 16;
                1: begin bo[i] = bo[i] % 4; bd[i] = bd[i] % 32; end
                2: begin
                    if (bo[i] == 1 || bo[i] >= 6) bo[i] = 4;
                    bd[i] = bd[i] % 16;
                end
                default: bo[i] = bo[i] % 2;
            endcase
        end
    endtask

    vec_t tab[15];

    initial begin
        int acc, n, base, nw;
        tab[0]  = '{0, 0, 'h05, 'h005, 0};
        tab[1]  = '{2, 0, 'h03, 'h103, 0};
        tab[2]  = '{1, 3, 'h06, 'h0E6, 0};
        tab[3]  = '{3, 1, 'h02, 'h1C2, 0};
        tab[4]  = '{2, 1, 'h00, 0, 1};
        tab[5]  = '{0, 0, 'h15, 0, 2};
        tab[6]  = '{1, 4, 'h01, 0, 2};
        tab[7]  = '{1, 2, 'h20, 0, 2};
        tab[8]  = '{3, 2, 'h00, 0, 2};
        tab[9]  = '{2, 6, 'h30, 0, 1};
        tab[10] = '{2, 7, 'h00, 0, 1};
        tab[11] = '{3, 0, 'h3F, 'h1BF, 0};
        tab[12] = '{0, 7, 'h0F, 'h07F, 0};
        tab[13] = '{1, 3, 'h1F, 'h0FF, 0};
        tab[14] = '{2, 5, 'h0F, 'h15F, 0};

        Reset_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_type = '0; in_op = '0; in_operand = '0; in_last = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rst in_ready", 32'(in_ready), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst err", 32'(err), 0);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst mem_wdata", 32'(mem_wdata), 0);
        check("rst err_code", 32'(err_code), 0);
        check("rst count", 32'(count), 0);

        // Single-instruction sessions against the hand-computed table.
        for (int i = 0; i < 15; i++) begin
            bt[0] = tab[i].t; bo[0] = tab[i].op; bd[0] = tab[i].opd; bl[0] = 1;
            exec(8'(16 + i), 1, acc);
            nw = (tab[i].code == 0) ? 1 : 0;
            check("vec nwrites", 32'(wr_addr.size()), 32'(nw));
            if (wr_addr.size() == 1 && nw == 1) begin
                check("vec addr", 32'(wr_addr[0]), 32'(16 + i));
                check("vec wdata", 32'(wr_data[0]), 32'(tab[i].word));
            end
            check("vec done", 32'(done), 32'(nw));
            check("vec err", 32'(err), 32'(1 - nw));
            check("vec err_code", 32'(err_code), 32'(tab[i].code));
            check("vec count", 32'(count), 32'(nw));
            check("vec in_ready", 32'(in_ready), 0);
        end

        // A new start clears the sticky error left by the last table entry.
        @(negedge Clk);
        start = 1'b1; base_addr = 8'h50;
        @(negedge Clk);
        start = 1'b0;
        check("restart err", 32'(err), 0);
        check("restart err_code", 32'(err_code), 0);
        check("restart busy", 32'(busy), 1);
        bt[0] = 0; bo[0] = 0; bd[0] = 1; bl[0] = 1;
        in_valid = 1'b1; in_type = 2'(bt[0]); in_op = 3'(bo[0]); in_operand = 6'(bd[0]); in_last = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge Clk);

        // Back-to-back li, beq, jmp.
        bt[0] = 2; bo[0] = 0; bd[0] = 'h03; bl[0] = 0;
        bt[1] = 1; bo[1] = 3; bd[1] = 'h06; bl[1] = 0;
        bt[2] = 3; bo[2] = 1; bd[2] = 'h02; bl[2] = 1;
        run_and_compare("b2b", 'h20, 3);
        if (wr_cyc.size() == 3) begin
            check("b2b gap01", 32'(wr_cyc[1] - wr_cyc[0]), 1);
            check("b2b gap12", 32'(wr_cyc[2] - wr_cyc[1]), 1);
        end

        // Memory bound: third bundle must be refused.
        for (int i = 0; i < 3; i++) begin
            bt[i] = 0; bo[i] = 1; bd[i] = i + 1; bl[i] = (i == 2) ? 1 : 0;
        end
        run_and_compare("memovf", 'hFE, 3);
        check("memovf acc2", 32'(wr_addr.size()), 2);

        // Last bundle exactly at the top address is legal.
        for (int i = 0; i < 2; i++) begin
            bt[i] = 3; bo[i] = 0; bd[i] = i; bl[i] = i;
        end
        run_and_compare("toplast", 'hFE, 2);

        // start during ACCEPT is ignored; in_valid outside ACCEPT does nothing.
        clear_log();
        @(negedge Clk);
        start = 1'b1; base_addr = 8'h40;
        @(negedge Clk);
        base_addr = 8'h80;
        in_valid = 1'b1; in_type = 2'b00; in_op = 3'b000; in_operand = 6'h01; in_last = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        in_operand = 6'h02; in_last = 1'b1;
        @(negedge Clk);
        in_last = 1'b0;
        repeat (3) @(negedge Clk);
        in_valid = 1'b0;
        check("ignstart nwrites", 32'(wr_addr.size()), 2);
        if (wr_addr.size() == 2) check("ignstart addr1", 32'(wr_addr[1]), 'h41);
        check("ignstart count", 32'(count), 2);

        // Reset mid-session with in_valid held high.
        @(negedge Clk);
        start = 1'b1; base_addr = 8'h30;
        @(negedge Clk);
        start = 1'b0;
        in_valid = 1'b1; in_type = 2'b00; in_op = 3'b000; in_operand = 6'h01; in_last = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("midrst mem_we", 32'(mem_we), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst count", 32'(count), 0);
        clear_log();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        check("midrst nwrites", 32'(wr_addr.size()), 0);
        check("midrst in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;

        // Random sessions against the reference model.
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(1, 6);
            base = ($urandom_range(0, 3) == 0) ? 252 + $urandom_range(0, 3) : $urandom_range(0, 255);
            for (int i = 0; i < n; i++) gen_bundle(i, (i == n - 1) ? 1 : 0);
            run_and_compare("rand", base, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
